// File: rtl/mfe_led7seg_display_arbiter.sv
// Shares one LED7seg display controller among REQ_NUM requesters: one frame buffer per
// requester, round-robin issue with a dwell gap. Define MFE_LED7SEG_ARB_FIXED_PRIO_EN for fixed priority.
module mfe_led7seg_display_arbiter #(
  parameter int                     REQ_NUM      = 4,
  parameter int                     DIG_NUM      = 8,
  parameter int                     SEG_NUM      = 8,
  parameter int                     DWELL_WIDTH  = 24,
  parameter logic [DWELL_WIDTH-1:0] DWELL_CYCLES = 24'd1_000_000,
  localparam int                    DAT_WIDTH    = DIG_NUM * SEG_NUM,
  localparam int                    IDX_WIDTH    = $clog2(REQ_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_NUM*DAT_WIDTH-1:0] req_dat,
  input  logic [REQ_NUM-1:0]           req_vld,
  output logic [REQ_NUM-1:0]           req_ack,
  output logic [DAT_WIDTH-1:0]         out_dat,
  output logic                         out_vld,
  output logic [IDX_WIDTH-1:0]         gnt_idx,
  output logic                         busy
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t                 state_q, state_d;
  logic [DAT_WIDTH-1:0]   slot_buf [REQ_NUM];
  logic [REQ_NUM-1:0]     pending_q;
  logic [DWELL_WIDTH-1:0] cnt_q;
  logic                   win_vld;
  logic [IDX_WIDTH-1:0]   win_idx;
  logic                   issue;
  logic [REQ_NUM-1:0]     grant_mask;

`ifdef MFE_LED7SEG_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest pending index is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_WIDTH'(i);
      end
    end
  end
`else
  logic [IDX_WIDTH-1:0] rr_ptr_q;

  // Scan offsets from far to near so the first pending slot at or after rr_ptr wins.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (pending_q[IDX_WIDTH'(idx)]) begin
        win_vld = 1'b1;
        win_idx = IDX_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (issue) begin
      rr_ptr_q <= (win_idx == IDX_WIDTH'(REQ_NUM - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`endif

  // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latch
  // is inferred; clocked blocks use non-blocking '<=' so all registers update from pre-edge values.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    grant_mask = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          issue      = 1'b1;
          grant_mask = REQ_NUM'(1) << win_idx;
          state_d    = DWELL;
        end
      end
      DWELL: begin
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      out_dat   <= '1;
      out_vld   <= 1'b0;
      req_ack   <= '0;
      gnt_idx   <= '0;
    end else begin
      state_q   <= state_d;
      out_vld   <= issue;
      req_ack   <= grant_mask;
      // A post on the slot being granted re-arms it: the old frame goes out, the new one waits.
      pending_q <= (pending_q & ~grant_mask) | req_vld;
      if (issue) begin
        out_dat <= slot_buf[win_idx];
        gnt_idx <= win_idx;
        cnt_q   <= DWELL_CYCLES - DWELL_WIDTH'(1);
      end else if (state_q == DWELL && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // NOTE: the frame buffers carry no reset; a slot is only read after a post has set its pending flag.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ_NUM; i++) begin
      if (req_vld[i]) slot_buf[i] <= req_dat[i*DAT_WIDTH +: DAT_WIDTH];
    end
  end

  assign busy = (state_q == DWELL);

endmodule

// File: tb/tb_mfe_led7seg_display_arbiter.sv
// Directed bench for mfe_led7seg_display_arbiter with a short dwell (8 cycles); the slot-0/slot-3
// contention scenario expects fixed priority when MFE_LED7SEG_ARB_FIXED_PRIO_EN is defined.
module tb_mfe_led7seg_display_arbiter;

  localparam int REQ_NUM = 4;
  localparam int DW      = 64;
  localparam int DWELL   = 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [REQ_NUM*DW-1:0]     req_dat = '0;
  logic [REQ_NUM-1:0]        req_vld = '0;
  logic [REQ_NUM-1:0]        req_ack;
  logic [DW-1:0]             out_dat;
  logic                      out_vld;
  logic [1:0]                gnt_idx;
  logic                      busy;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] frm [REQ_NUM];

  mfe_led7seg_display_arbiter #(
    .REQ_NUM(REQ_NUM), .DIG_NUM(8), .SEG_NUM(8), .DWELL_WIDTH(24), .DWELL_CYCLES(24'd8)
  ) dut (
    .clk(clk), .rst(rst), .req_dat(req_dat), .req_vld(req_vld), .req_ack(req_ack),
    .out_dat(out_dat), .out_vld(out_vld), .gnt_idx(gnt_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_vld = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Drive one post pulse for every slot in mask, taking frames from frm[].
  task automatic post(input logic [REQ_NUM-1:0] mask);
    for (int i = 0; i < REQ_NUM; i++)
      if (mask[i]) req_dat[i*DW +: DW] = frm[i];
    req_vld = mask;
    tick();
    req_vld = '0;
  endtask

  task automatic wait_issue(input int budget, output int n);
    n = 0;
    while (1) begin
      tick();
      n++;
      if (out_vld === 1'b1) break;
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: no out_vld within %0d cycles", budget);
        break;
      end
    end
  endtask

  task automatic expect_issue(input string name, input int n, input int exp_n,
                              input int slot, input logic [DW-1:0] exp_dat);
    logic [REQ_NUM-1:0] exp_ack;
    exp_ack = REQ_NUM'(1) << slot;
    checks++;
    if (n !== exp_n) begin
      errors++; $display("FAIL %s_spacing: got %0d cycles want %0d", name, n, exp_n);
    end
    checks++;
    if (req_ack !== exp_ack) begin
      errors++; $display("FAIL %s_ack: got %b want %b", name, req_ack, exp_ack);
    end
    checks++;
    if (gnt_idx !== 2'(slot)) begin
      errors++; $display("FAIL %s_gnt: got %0d want %0d", name, gnt_idx, slot);
    end
    checks++;
    if (out_dat !== exp_dat) begin
      errors++; $display("FAIL %s_dat: got %h want %h", name, out_dat, exp_dat);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_dat !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL reset_dat: got %h want all ones", out_dat);
    end
    checks++;
    if ({out_vld, busy, gnt_idx, req_ack} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctl: vld=%b busy=%b gnt=%0d ack=%b want all 0", out_vld, busy, gnt_idx, req_ack);
    end
  endtask

  task automatic test_single_post();
    do_reset();
    frm[2] = 64'hF8828292_99B0A4F9;
    post(4'b0100);
    checks++;
    if (out_vld !== 1'b0) begin
      errors++; $display("FAIL single_early: out_vld got %b want 0 one cycle after post", out_vld);
    end
    tick();
    checks++;
    if (out_vld !== 1'b1) begin
      errors++; $display("FAIL single_vld: got %b want 1", out_vld);
    end
    expect_issue("single", 1, 1, 2, 64'hF8828292_99B0A4F9);
    for (int i = 0; i < DWELL; i++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL single_busy: cycle %0d got %b want 1", i, busy);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    frm[0] = 64'h1111_0000_0000_0000; frm[1] = 64'h2222_0000_0000_0001;
    frm[2] = 64'h3333_0000_0000_0002; frm[3] = 64'h4444_0000_0000_0003;
    post(4'b1111);
    for (int k = 0; k < REQ_NUM; k++) begin
      wait_issue(20, n);
      expect_issue("rr", n, (k == 0) ? 1 : DWELL + 1, k, frm[k]);
    end
    frm[0] = 64'hAAAA_5555_0000_0000; frm[3] = 64'hBBBB_6666_0000_0003;
    post(4'b1001);
    wait_issue(20, n);
    expect_issue("rr_wrap0", n, DWELL, 0, frm[0]);
    wait_issue(20, n);
    expect_issue("rr_wrap3", n, DWELL + 1, 3, frm[3]);
  endtask

  task automatic test_overwrite();
    int n;
    int extra;
    do_reset();
    frm[0] = 64'h0F0F_0F0F_0F0F_0F0F;
    post(4'b0001);
    wait_issue(20, n);
    frm[1] = 64'hAAAA_AAAA_AAAA_AAAA;
    post(4'b0010);
    frm[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    post(4'b0010);
    wait_issue(20, n);
    expect_issue("ovw", n, DWELL - 1, 1, 64'hBBBB_BBBB_BBBB_BBBB);
    extra = 0;
    for (int i = 0; i < 3 * DWELL; i++) begin
      tick();
      if (out_vld === 1'b1 || req_ack !== '0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL ovw_single_ack: got %0d extra issues want 0", extra);
    end

    // Post onto slot 1 on the very edge that grants it.
    do_reset();
    post(4'b0001);
    wait_issue(20, n);
    frm[1] = 64'hC0C0_C0C0_C0C0_C0C0;
    post(4'b0010);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    req_dat[DW +: DW] = 64'hD1D1_D1D1_D1D1_D1D1;
    req_vld = 4'b0010;
    tick();
    req_vld = '0;
    checks++;
    if (out_vld !== 1'b1) begin
      errors++; $display("FAIL same_edge_vld: got %b want 1", out_vld);
    end
    expect_issue("same_edge_old", 1, 1, 1, 64'hC0C0_C0C0_C0C0_C0C0);
    wait_issue(20, n);
    expect_issue("same_edge_new", n, DWELL + 1, 1, 64'hD1D1_D1D1_D1D1_D1D1);
  endtask

  task automatic test_reset_mid_dwell();
    int n;
    int seen;
    do_reset();
    frm[0] = 64'h1234_5678_9ABC_DEF0;
    post(4'b0001);
    wait_issue(20, n);
    frm[1] = 64'h1; frm[3] = 64'h3;
    post(4'b1010);
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (out_dat !== 64'hFFFF_FFFF_FFFF_FFFF || busy !== 1'b0 || out_vld !== 1'b0) begin
      errors++; $display("FAIL midrst_state: dat=%h busy=%b vld=%b want ones/0/0", out_dat, busy, out_vld);
    end
    seen = 0;
    for (int i = 0; i < 4 * DWELL; i++) begin
      tick();
      if (out_vld === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_pending: got %0d issues after reset want 0", seen);
    end
  endtask

  // Slots 0 and 3 repost every cycle: fixed priority serves only 0, round-robin alternates 0,3.
  task automatic test_contention();
    int issues;
    int bad;
    logic [REQ_NUM-1:0] exp_ack;
    do_reset();
    frm[0] = 64'h00; frm[3] = 64'h33;
    req_dat[0 +: DW] = frm[0];
    req_dat[3*DW +: DW] = frm[3];
    issues = 0;
    bad = 0;
    for (int i = 0; i < 6 * (DWELL + 1); i++) begin
      req_vld = 4'b1001;
      tick();
      if (out_vld === 1'b1) begin
`ifdef MFE_LED7SEG_ARB_FIXED_PRIO_EN
        exp_ack = 4'b0001;
`else
        exp_ack = (issues % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
        if (req_ack !== exp_ack) begin
          bad++;
          $display("FAIL contention_ack: issue %0d got %b want %b", issues, req_ack, exp_ack);
        end
        issues++;
      end
    end
    req_vld = '0;
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (issues < 5) begin
      errors++; $display("FAIL contention_count: got %0d issues want at least 5", issues);
    end
  endtask

  initial begin
    for (int i = 0; i < REQ_NUM; i++) frm[i] = '0;
    test_reset();
    test_single_post();
    test_round_robin();
    test_overwrite();
    test_reset_mid_dwell();
    test_contention();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
